// File: rtl/cavlc_shift_arbiter.sv
// Round-robin arbiter sharing one bitstream barrel shifter among the CAVLC
// syntax-element decoders; issues paced registered shift commands and counts consumed bits.
module cavlc_shift_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*SHIFT_W-1:0] i_req_shift,
    output logic [NUM_REQ-1:0]         o_grant,
    input  logic                       i_barrel_shifter_ready,
    output logic                       o_shift_en,
    output logic [SHIFT_W-1:0]         o_num_shift,
    input  logic                       i_clr_count,
    output logic [CNT_W-1:0]           o_bits_consumed,
    output logic                       o_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COOLDOWN
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_shift_en;
    logic [SHIFT_W-1:0]   r_num_shift;
    logic [CNT_W-1:0]     r_bits;

    logic                 w_take;
    logic                 w_win_found;
    logic [PTR_W-1:0]     w_win_idx;
    logic [PTR_W-1:0]     w_ptr_next;
    logic [SHIFT_W-1:0]   w_win_amt;
    logic [PTR_W:0]       w_cand;

    // Round-robin search: first set request at or after r_ptr, wrapping modulo NUM_REQ.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_cand >= (PTR_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_win_found && i_req[w_cand[PTR_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_amt  = i_req_shift[w_win_idx*SHIFT_W +: SHIFT_W];
        w_ptr_next = (w_win_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_win_idx + 1'b1;
        w_take     = (r_state == S_IDLE) && i_enable && i_barrel_shifter_ready && w_win_found;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_take) w_next_state = S_ISSUE;
            // A zero-amount issue never touched the shifter, so no cooldown is needed.
            S_ISSUE:    w_next_state = (r_num_shift != '0) ? S_COOLDOWN : S_IDLE;
            S_COOLDOWN: w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr       <= '0;
            r_grant     <= '0;
            r_shift_en  <= 1'b0;
            r_num_shift <= '0;
        end else begin
            r_grant     <= '0;
            r_shift_en  <= 1'b0;
            r_num_shift <= '0;
            if (w_take) begin
                r_grant     <= NUM_REQ'(1) << w_win_idx;
                r_shift_en  <= |w_win_amt;
                r_num_shift <= w_win_amt;
                r_ptr       <= w_ptr_next;
            end
        end
    end

    // Clear wins over accumulate, but a coincident shift is still counted after the clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bits <= '0;
        end else if (i_clr_count) begin
            r_bits <= r_shift_en ? CNT_W'(r_num_shift) : '0;
        end else if (r_shift_en) begin
            r_bits <= r_bits + CNT_W'(r_num_shift);
        end
    end

    assign o_grant         = r_grant;
    assign o_shift_en      = r_shift_en;
    assign o_num_shift     = r_num_shift;
    assign o_bits_consumed = r_bits;
    assign o_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_cavlc_shift_arbiter.sv
// Self-checking bench for cavlc_shift_arbiter: a cycle-level behavioural model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_cavlc_shift_arbiter;

    localparam int NREQ = 4;
    localparam int SW   = 5;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            ready;
    logic            clr;
    logic [NREQ-1:0] req;
    logic [NREQ*SW-1:0] req_shift;
    logic [NREQ-1:0] o_grant;
    logic            o_shift_en;
    logic [SW-1:0]   o_num_shift;
    logic [CW-1:0]   o_bits_consumed;
    logic            o_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: a blocking window after each grant, a round-robin pointer and a sum.
    int m_block = 0;
    int m_ptr   = 0;
    int m_bits  = 0;
    int e_grant = 0;
    int e_en    = 0;
    int e_num   = 0;

    cavlc_shift_arbiter #(.NUM_REQ(NREQ), .SHIFT_W(SW), .CNT_W(CW)) dut (
        .i_clk                  (clk),
        .i_reset                (reset),
        .i_enable               (enable),
        .i_req                  (req),
        .i_req_shift            (req_shift),
        .o_grant                (o_grant),
        .i_barrel_shifter_ready (ready),
        .o_shift_en             (o_shift_en),
        .o_num_shift            (o_num_shift),
        .i_clr_count            (clr),
        .o_bits_consumed        (o_bits_consumed),
        .o_busy                 (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_amt(input int i, input int v);
        req_shift[i*SW +: SW] = SW'(v);
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) begin
        int w;
        int amt;
        cyc++;
        if (reset) begin
            m_block = 0; m_ptr = 0; m_bits = 0;
            e_grant = 0; e_en = 0; e_num = 0;
        end else begin
            if (clr) m_bits = (e_en != 0) ? e_num : 0;
            else if (e_en != 0) m_bits = (m_bits + e_num) & 16'hFFFF;
            e_grant = 0; e_en = 0; e_num = 0;
            if (m_block > 0) begin
                m_block--;
            end else if (enable && ready && (req != 0)) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
                amt     = int'(req_shift[w*SW +: SW]);
                e_grant = 1 << w;
                e_num   = amt;
                e_en    = (amt != 0) ? 1 : 0;
                m_block = (amt != 0) ? 2 : 1;
                m_ptr   = (w + 1) % NREQ;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("cmp_grant", 32'(o_grant), 32'(e_grant));
            check("cmp_shift_en", 32'(o_shift_en), 32'(e_en));
            check("cmp_num_shift", 32'(o_num_shift), 32'(e_num));
            check("cmp_bits", 32'(o_bits_consumed), 32'(m_bits));
            check("cmp_busy", 32'(o_busy), (m_block > 0) ? 32'd1 : 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int last;
        int got [5];
        int exp_order [5] = '{0, 1, 2, 3, 0};

        reset = 1'b1; enable = 1'b0; ready = 1'b0; clr = 1'b0;
        req = '0; req_shift = '0;
        step(); step();
        check("reset_grant", 32'(o_grant), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_bits", 32'(o_bits_consumed), 32'd0);
        reset = 1'b0; enable = 1'b1; ready = 1'b1;
        step();

        // Single request of 7 bits.
        req = 4'b0001; set_amt(0, 7);
        step();
        check("single_grant", 32'(o_grant), 32'h1);
        check("single_shift_en", 32'(o_shift_en), 32'd1);
        check("single_num", 32'(o_num_shift), 32'd7);
        check("single_busy1", 32'(o_busy), 32'd1);
        req = '0;
        step();
        check("single_grant_off", 32'(o_grant), 32'd0);
        check("single_busy2", 32'(o_busy), 32'd1);
        check("single_bits", 32'(o_bits_consumed), 32'd7);
        step();
        check("single_idle", 32'(o_busy), 32'd0);

        // Ready stall: nothing happens until the shifter is ready.
        req = 4'b0100; set_amt(2, 3); ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_no_grant", 32'(o_grant), 32'd0);
            check("stall_not_busy", 32'(o_busy), 32'd0);
        end
        ready = 1'b1;
        step();
        check("stall_grant", 32'(o_grant), 32'h4);
        check("stall_num", 32'(o_num_shift), 32'd3);
        req = '0;
        step(); step();

        // Zero shift skips cooldown; the next pending requester wins at t+3.
        req = 4'b0010; set_amt(1, 0); set_amt(3, 4);
        step();
        check("zero_grant", 32'(o_grant), 32'h2);
        check("zero_shift_en", 32'(o_shift_en), 32'd0);
        check("zero_num", 32'(o_num_shift), 32'd0);
        req = 4'b1000;
        step();
        check("zero_idle_t2", 32'(o_busy), 32'd0);
        step();
        check("zero_next_grant", 32'(o_grant), 32'h8);
        check("zero_next_num", 32'(o_num_shift), 32'd4);
        req = '0;
        step(); step();

        // Enable low while idle blocks new arbitration.
        enable = 1'b0; req = 4'b0001; set_amt(0, 7);
        for (int i = 0; i < 3; i++) begin
            step();
            check("enable_low_grant", 32'(o_grant), 32'd0);
        end
        req = '0; enable = 1'b1;
        step();

        // Round robin with all four requesting.
        clr = 1'b1;
        step();
        clr = 1'b0;
        req = 4'b1111; set_amt(0, 1); set_amt(1, 2); set_amt(2, 3); set_amt(3, 4);
        n = 0; last = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            step();
            if (o_grant != '0) begin
                got[n] = oh_idx(o_grant);
                if (n > 0) check("rr_spacing", 32'(c - last), 32'd3);
                last = c;
                n++;
            end
        end
        check("rr_count", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) check("rr_order", 32'(got[i]), 32'(exp_order[i]));
        step();
        check("rr_bits", 32'(o_bits_consumed), 32'd11);
        req = '0;
        step(); step();

        // Counter wrap: 2114 x 31 = 0xFFFE, then +5 wraps to 3, then clear+9 gives 9.
        clr = 1'b1;
        step();
        clr = 1'b0;
        req = 4'b0001; set_amt(0, 31);
        n = 0;
        for (int c = 0; c < 8000 && n < 2114; c++) begin
            step();
            if (o_grant != '0) n++;
        end
        check("wrap_grants", 32'(n), 32'd2114);
        set_amt(0, 5);
        step(); step(); step();
        check("wrap_pre_grant", 32'(o_grant), 32'h1);
        check("wrap_pre_bits", 32'(o_bits_consumed), 32'hFFFE);
        check("wrap_pre_num", 32'(o_num_shift), 32'd5);
        set_amt(0, 9);
        step();
        check("wrap_bits", 32'(o_bits_consumed), 32'h3);
        step(); step();
        check("clr_grant", 32'(o_grant), 32'h1);
        check("clr_num", 32'(o_num_shift), 32'd9);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_with_shift", 32'(o_bits_consumed), 32'd9);
        req = '0;
        step(); step();

        // Reset during ISSUE drops the issue and returns the pointer to 0.
        req = 4'b0100; set_amt(2, 6);
        step();
        check("rst_mid_grant", 32'(o_grant), 32'h4);
        reset = 1'b1; req = '0;
        step();
        check("rst_mid_grant0", 32'(o_grant), 32'd0);
        check("rst_mid_en0", 32'(o_shift_en), 32'd0);
        check("rst_mid_num0", 32'(o_num_shift), 32'd0);
        check("rst_mid_bits0", 32'(o_bits_consumed), 32'd0);
        check("rst_mid_busy0", 32'(o_busy), 32'd0);
        reset = 1'b0; req = 4'b1010; set_amt(1, 2); set_amt(3, 4);
        step();
        check("rst_ptr_lowest", 32'(o_grant), 32'h2);
        check("rst_ptr_num", 32'(o_num_shift), 32'd2);
        req = '0;
        step(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
